// File: rtl/vc_allocator_mvc.sv
// Multi-VC separable input-first virtual-channel allocator with round-robin
// fairness at both stages and round-robin downstream VC selection.
module vc_allocator_mvc #(
  parameter int unsigned PORT_NUM  = 5,
  parameter int unsigned VC_NUM    = 2,
  parameter int unsigned VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int unsigned PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [PORT_NUM*VC_NUM-1:0]           idle_downstream_vc_i,
  input  logic [PORT_NUM*VC_NUM-1:0]           vc_request_i,
  input  logic [PORT_NUM*VC_NUM*PORT_SIZE-1:0] out_port_i,
  output logic [PORT_NUM*VC_NUM-1:0]           vc_valid_o,
  output logic [PORT_NUM*VC_NUM*VC_SIZE-1:0]   vc_new_o
);

  localparam int unsigned N = PORT_NUM * VC_NUM;

  logic [N-1:0]         avail;
  logic [VC_SIZE-1:0]   in_ptr  [PORT_NUM];
  logic [PORT_SIZE-1:0] out_ptr [PORT_NUM];
  logic [VC_SIZE-1:0]   vc_ptr  [PORT_NUM];

  logic [PORT_SIZE-1:0] tgt [N];
  logic [PORT_NUM-1:0]  port_has_vc;
  logic [N-1:0]         elig;

  logic [PORT_NUM-1:0]  s1_valid;
  logic [VC_SIZE-1:0]   s1_vc  [PORT_NUM];
  logic [PORT_SIZE-1:0] s1_tgt [PORT_NUM];

  logic [PORT_NUM-1:0]  s2_valid;
  logic [PORT_SIZE-1:0] s2_port [PORT_NUM];
  logic [VC_SIZE-1:0]   sel_vc  [PORT_NUM];

  logic [PORT_NUM-1:0]  in_upd;
  logic [VC_SIZE-1:0]   in_nxt [PORT_NUM];

  // Eligibility: in-range target port that still owns a free VC
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      port_has_vc[o] = |avail[o*VC_NUM +: VC_NUM];
    end
    for (int i = 0; i < N; i++) begin
      tgt[i]  = out_port_i[i*PORT_SIZE +: PORT_SIZE];
      elig[i] = 1'b0;
      for (int o = 0; o < PORT_NUM; o++) begin
        if (vc_request_i[i] && (tgt[i] == PORT_SIZE'(o)) && port_has_vc[o]) elig[i] = 1'b1;
      end
    end
  end

  // Round-robin as two passes: indices at/after the pointer, then the wrapped ones
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      s1_valid[p] = 1'b0;
      s1_vc[p]    = '0;
      s1_tgt[p]   = '0;
      for (int pass = 0; pass < 2; pass++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          if (!s1_valid[p] && elig[p*VC_NUM+v] &&
              ((pass == 0) == (VC_SIZE'(v) >= in_ptr[p]))) begin
            s1_valid[p] = 1'b1;
            s1_vc[p]    = VC_SIZE'(v);
            s1_tgt[p]   = tgt[p*VC_NUM+v];
          end
        end
      end
    end
  end

  // Output-port arbitration and downstream VC pick
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      s2_valid[o] = 1'b0;
      s2_port[o]  = '0;
      for (int pass = 0; pass < 2; pass++) begin
        for (int p = 0; p < PORT_NUM; p++) begin
          if (!s2_valid[o] && s1_valid[p] && (s1_tgt[p] == PORT_SIZE'(o)) &&
              ((pass == 0) == (PORT_SIZE'(p) >= out_ptr[o]))) begin
            s2_valid[o] = 1'b1;
            s2_port[o]  = PORT_SIZE'(p);
          end
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      sel_vc[o] = '0;
      for (int pass = 1; pass >= 0; pass--) begin
        for (int d = VC_NUM - 1; d >= 0; d--) begin
          if (avail[o*VC_NUM+d] && ((pass == 0) == (VC_SIZE'(d) >= vc_ptr[o]))) begin
            sel_vc[o] = VC_SIZE'(d);
          end
        end
      end
    end
  end

  // Map output grants back to the requesting upstream VC
  always_comb begin
    vc_valid_o = '0;
    vc_new_o   = '0;
    in_upd     = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      in_nxt[p] = (s1_vc[p] == VC_SIZE'(VC_NUM - 1)) ? '0 : s1_vc[p] + VC_SIZE'(1);
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (!rst && s2_valid[o] && (s2_port[o] == PORT_SIZE'(p))) begin
          in_upd[p] = 1'b1;
          for (int v = 0; v < VC_NUM; v++) begin
            if (s1_vc[p] == VC_SIZE'(v)) begin
              vc_valid_o[p*VC_NUM+v]                    = 1'b1;
              vc_new_o[(p*VC_NUM+v)*VC_SIZE +: VC_SIZE] = sel_vc[o];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      avail <= '1;
      for (int p = 0; p < PORT_NUM; p++) begin
        in_ptr[p]  <= '0;
        out_ptr[p] <= '0;
        vc_ptr[p]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!avail[i] && idle_downstream_vc_i[i]) avail[i] <= 1'b1;
      end
      for (int p = 0; p < PORT_NUM; p++) begin
        if (in_upd[p]) in_ptr[p] <= in_nxt[p];
      end
      // Grant and release never address the same VC, so ordering here is moot
      for (int o = 0; o < PORT_NUM; o++) begin
        if (s2_valid[o]) begin
          out_ptr[o] <= (s2_port[o] == PORT_SIZE'(PORT_NUM - 1)) ? '0 : s2_port[o] + PORT_SIZE'(1);
          vc_ptr[o]  <= (sel_vc[o] == VC_SIZE'(VC_NUM - 1)) ? '0 : sel_vc[o] + VC_SIZE'(1);
          for (int d = 0; d < VC_NUM; d++) begin
            if (sel_vc[o] == VC_SIZE'(d)) avail[o*VC_NUM+d] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vc_allocator_mvc.sv
// Directed self-checking bench for vc_allocator_mvc (PORT_NUM=5, VC_NUM=2).
module tb_vc_allocator_mvc;

  localparam int unsigned PORT_NUM  = 5;
  localparam int unsigned VC_NUM    = 2;
  localparam int unsigned VC_SIZE   = 1;
  localparam int unsigned PORT_SIZE = 3;
  localparam int unsigned N         = PORT_NUM * VC_NUM;

  logic                   clk;
  logic                   rst;
  logic [N-1:0]           idle;
  logic [N-1:0]           req;
  logic [N*PORT_SIZE-1:0] out_port;
  logic [N-1:0]           vc_valid;
  logic [N*VC_SIZE-1:0]   vc_new;

  int checks   = 0;
  int failures = 0;

  vc_allocator_mvc #(
    .PORT_NUM(PORT_NUM),
    .VC_NUM  (VC_NUM)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .idle_downstream_vc_i(idle),
    .vc_request_i        (req),
    .out_port_i          (out_port),
    .vc_valid_o          (vc_valid),
    .vc_new_o            (vc_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    req      = '0;
    idle     = '0;
    out_port = '0;
  endtask

  task automatic set_req(input int p, input int v, input int port);
    req[p*VC_NUM+v] = 1'b1;
    out_port[(p*VC_NUM+v)*PORT_SIZE +: PORT_SIZE] = PORT_SIZE'(port);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    tick();
    rst = 1'b0;
  endtask

  // Output contention: grants rotate 0,1,4,0 while port-1 VCs alternate 0,1
  logic [31:0] cont_valid [4] = '{32'h001, 32'h004, 32'h200, 32'h001};
  logic [31:0] cont_new   [4] = '{32'h000, 32'h004, 32'h000, 32'h001};

  initial begin
    rst = 1'b1;
    clear_in();
    set_req(0, 0, 2);
    sample();
    check("rst_valid", 32'(vc_valid), 32'h0);
    check("rst_new", 32'(vc_new), 32'h0);
    tick();
    rst = 1'b0;

    // Single request after reset
    sample();
    check("single_valid", 32'(vc_valid), 32'h001);
    check("single_new", 32'(vc_new), 32'h000);
    tick();
    clear_in();
    set_req(1, 0, 2);
    sample();
    check("single_next_valid", 32'(vc_valid), 32'h004);
    check("single_next_new", 32'(vc_new), 32'h004);
    tick();
    clear_in();
    set_req(0, 1, 2);
    sample();
    check("single_full", 32'(vc_valid), 32'h0);
    tick();

    // Exhaustion of port 3 and release via idle
    do_reset();
    set_req(0, 0, 3);
    sample();
    check("exh_g1_valid", 32'(vc_valid), 32'h001);
    check("exh_g1_new", 32'(vc_new), 32'h000);
    tick();
    clear_in();
    set_req(1, 0, 3);
    sample();
    check("exh_g2_valid", 32'(vc_valid), 32'h004);
    check("exh_g2_new", 32'(vc_new), 32'h004);
    tick();
    clear_in();
    set_req(2, 0, 3);
    sample();
    check("exh_blocked", 32'(vc_valid), 32'h0);
    tick();
    idle[3*VC_NUM+1] = 1'b1;
    sample();
    check("exh_idle_same_cycle", 32'(vc_valid), 32'h0);
    tick();
    idle = '0;
    sample();
    check("exh_release_valid", 32'(vc_valid), 32'h010);
    check("exh_release_new", 32'(vc_new), 32'h010);
    tick();

    // Output-port contention with continuous idle release
    do_reset();
    set_req(0, 0, 1);
    set_req(1, 0, 1);
    set_req(4, 1, 1);
    idle = '1;
    for (int c = 0; c < 4; c++) begin
      sample();
      check($sformatf("cont_valid_%0d", c), 32'(vc_valid), cont_valid[c]);
      check($sformatf("cont_new_%0d", c), 32'(vc_new), cont_new[c]);
      tick();
    end

    // Input-port contention: one grant per input port per cycle, alternating VCs
    do_reset();
    set_req(2, 0, 0);
    set_req(2, 1, 1);
    sample();
    check("inp_c0_valid", 32'(vc_valid), 32'h010);
    check("inp_c0_new", 32'(vc_new), 32'h000);
    tick();
    sample();
    check("inp_c1_valid", 32'(vc_valid), 32'h020);
    check("inp_c1_new", 32'(vc_new), 32'h000);
    tick();
    sample();
    check("inp_c2_valid", 32'(vc_valid), 32'h010);
    check("inp_c2_new", 32'(vc_new), 32'h010);
    tick();

    // Out-of-range target ports are never granted and change nothing
    do_reset();
    set_req(3, 0, 5);
    set_req(4, 0, 7);
    sample();
    check("oor_c0", 32'(vc_valid), 32'h0);
    tick();
    sample();
    check("oor_c1", 32'(vc_valid), 32'h0);
    tick();
    clear_in();
    set_req(3, 1, 0);
    sample();
    check("oor_after_valid", 32'(vc_valid), 32'h080);
    check("oor_after_new", 32'(vc_new), 32'h000);
    tick();

    // Reset in the middle of operation discards allocations
    do_reset();
    set_req(0, 0, 2);
    set_req(1, 0, 0);
    sample();
    check("mid_a1_valid", 32'(vc_valid), 32'h005);
    check("mid_a1_new", 32'(vc_new), 32'h000);
    tick();
    sample();
    check("mid_a2_valid", 32'(vc_valid), 32'h005);
    check("mid_a2_new", 32'(vc_new), 32'h005);
    tick();
    clear_in();
    set_req(0, 0, 2);
    sample();
    check("mid_full", 32'(vc_valid), 32'h0);
    tick();
    rst = 1'b1;
    sample();
    check("mid_rst_valid", 32'(vc_valid), 32'h0);
    tick();
    rst = 1'b0;
    sample();
    check("mid_post_valid", 32'(vc_valid), 32'h001);
    check("mid_post_new", 32'(vc_new), 32'h000);
    tick();
    clear_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
